// File: rtl/leaf_pkt_pkg.sv
// Shared packet layout, credit sizing and per-port flow state for the leaf
// outbound path.
package leaf_pkt_pkg;

  localparam int unsigned PKT_W  = 49;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEAF_W = 5;
  localparam int unsigned PORT_W = 4;
  localparam int unsigned ADDR_W = 7;

  localparam int unsigned VALID_BIT = 48;
  localparam int unsigned LEAF_LSB  = 43;
  localparam int unsigned PORT_LSB  = 39;
  localparam int unsigned ADDR_LSB  = 32;

  localparam int unsigned DEF_MAX_CREDITS = 64;
  localparam int unsigned CREDIT_BITS     = $clog2(DEF_MAX_CREDITS + 1);

  typedef enum logic {
    ACTIVE,
    STALLED
  } port_state_e;

  // Build a valid packet {1, leaf, port, addr, payload}.
  function automatic logic [PKT_W-1:0] pack_pkt(
    input logic [LEAF_W-1:0] leaf,
    input logic [PORT_W-1:0] port,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] payload
  );
    logic [PKT_W-1:0] p;
    p = '0;
    p[VALID_BIT]             = 1'b1;
    p[LEAF_LSB +: LEAF_W]    = leaf;
    p[PORT_LSB +: PORT_W]    = port;
    p[ADDR_LSB +: ADDR_W]    = addr;
    p[0 +: DATA_W]           = payload;
    return p;
  endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the
// last granted index; the pointer moves only on the advance strobe.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] pick;

  // Prefer requesters above last_grant, else wrap to the full vector; the
  // lowest set bit of the chosen vector is the winner.
  always_comb begin
    hi_mask = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      hi_mask[k] = (k > 32'(last_grant));
    end
    pick  = (|(req & hi_mask)) ? (req & hi_mask) : req;
    grant = pick & (~pick + NUM_REQ'(1));
    grant_idx = last_grant;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) grant_idx = IDX_W'(k);
    end
  end

  // Pointer register; starts at the top index so port 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (advance) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Shares one outbound BFT packet channel between user output streams with
// round-robin arbitration, per-port credits, and destination stamping.
module leaf_out_arbiter
  import leaf_pkt_pkg::*;
#(
  parameter int unsigned PACKET_BITS   = 49,
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_LEAF_BITS = 5,
  parameter int unsigned NUM_PORT_BITS = 4,
  parameter int unsigned NUM_ADDR_BITS = 7,
  parameter int unsigned NUM_OUT_PORTS = 4,
  parameter int unsigned MAX_CREDITS   = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] i_user_data,
  input  logic [NUM_OUT_PORTS-1:0]              i_user_valid,
  output logic [NUM_OUT_PORTS-1:0]              o_user_ready,
  output logic [PACKET_BITS-1:0]                o_pkt,
  output logic                                  o_pkt_valid,
  input  logic                                  i_pkt_ready,
  input  logic                                  cfg_we,
  input  logic [2:0]                            cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dest,
  input  logic                                  credit_ret,
  input  logic [2:0]                            credit_port,
  input  logic [6:0]                            credit_amt,
  output logic                                  credit_err
);

  localparam int unsigned DEST_W = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int unsigned CW = ($clog2(MAX_CREDITS + 1) > CREDIT_BITS) ?
                               $clog2(MAX_CREDITS + 1) : CREDIT_BITS;

  logic [DEST_W-1:0]        dest_tbl     [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] dest_en;
  logic [CW-1:0]            credits      [NUM_OUT_PORTS];
  logic [CW-1:0]            credits_next [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq          [NUM_OUT_PORTS];
  port_state_e              state_q      [NUM_OUT_PORTS];
  port_state_e              state_d      [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic                     out_free;
  logic                     xfer;
  logic                     err_next;
  logic [PACKET_BITS-1:0]   pkt_next;

  rr_arbiter #(
    .NUM_REQ (NUM_OUT_PORTS)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (eligible),
    .advance (xfer),
    .grant   (grant)
  );

  // Handshake: a grant transfers only when the output register is free.
  always_comb begin
    out_free     = !o_pkt_valid || i_pkt_ready;
    xfer         = out_free && (|grant);
    o_user_ready = out_free ? grant : '0;
  end

  // Select the granted stream and stamp it with its destination and sequence.
  always_comb begin
    pkt_next = '0;
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      if (grant[k]) begin
        pkt_next = pack_pkt(dest_tbl[k][DEST_W-1 -: NUM_LEAF_BITS],
                            dest_tbl[k][NUM_PORT_BITS-1:0],
                            seq[k],
                            i_user_data[k*PAYLOAD_BITS +: PAYLOAD_BITS]);
      end
    end
  end

  // Net credit update (decrement and return in one cycle), with saturation
  // and out-of-range index detection feeding the sticky error.
  always_comb begin
    int unsigned sum;
    sum      = 0;
    err_next = 1'b0;
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      sum = 32'(credits[k]);
      if (xfer && grant[k]) sum = sum - 1;
      if (credit_ret && (32'(credit_port) == k)) sum = sum + 32'(credit_amt);
      if (sum > MAX_CREDITS) begin
        sum      = MAX_CREDITS;
        err_next = 1'b1;
      end
      credits_next[k] = CW'(sum);
    end
    if (credit_ret && (32'(credit_port) >= NUM_OUT_PORTS)) err_next = 1'b1;
    if (cfg_we && (32'(cfg_port) >= NUM_OUT_PORTS)) err_next = 1'b1;
  end

  // Per-port flow state next-state: stalled exactly when no credits remain.
  always_comb begin
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      state_d[k] = (credits_next[k] == '0) ? STALLED : ACTIVE;
    end
  end

  // Per-port flow state output: request only when valid, enabled and active.
  always_comb begin
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      eligible[k] = i_user_valid[k] && dest_en[k] && (state_q[k] == ACTIVE);
    end
  end

  // Per-port flow state register.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      if (reset) state_q[k] <= ACTIVE;
      else       state_q[k] <= state_d[k];
    end
  end

  // Credit, sequence and destination table state plus the sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
        credits[k]  <= CW'(MAX_CREDITS);
        seq[k]      <= '0;
        dest_tbl[k] <= '0;
      end
      dest_en    <= '0;
      credit_err <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
        credits[k] <= credits_next[k];
        if (xfer && grant[k]) seq[k] <= seq[k] + 1'b1;
        if (cfg_we && (32'(cfg_port) == k)) begin
          dest_tbl[k] <= cfg_dest;
          dest_en[k]  <= 1'b1;
        end
      end
      credit_err <= credit_err | err_next;
    end
  end

  // Output register: load on transfer, clear once drained, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_pkt       <= '0;
      o_pkt_valid <= 1'b0;
    end else if (xfer) begin
      o_pkt       <= pkt_next;
      o_pkt_valid <= 1'b1;
    end else if (i_pkt_ready) begin
      o_pkt       <= '0;
      o_pkt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Scoreboard bench for leaf_out_arbiter: a rule-level reference model
// predicts grants, credit errors and outbound packets; a monitor pops and
// compares each packet as it leaves.
module tb_leaf_out_arbiter;

  localparam int N    = 4;
  localparam int MAXC = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*32-1:0] i_user_data;
  logic [N-1:0]  i_user_valid;
  logic [N-1:0]  o_user_ready;
  logic [48:0]   o_pkt;
  logic          o_pkt_valid;
  logic          i_pkt_ready;
  logic          cfg_we;
  logic [2:0]    cfg_port;
  logic [8:0]    cfg_dest;
  logic          credit_ret;
  logic [2:0]    credit_port;
  logic [6:0]    credit_amt;
  logic          credit_err;

  leaf_out_arbiter #(
    .NUM_OUT_PORTS (N),
    .MAX_CREDITS   (MAXC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_user_data  (i_user_data),
    .i_user_valid (i_user_valid),
    .o_user_ready (o_user_ready),
    .o_pkt        (o_pkt),
    .o_pkt_valid  (o_pkt_valid),
    .i_pkt_ready  (i_pkt_ready),
    .cfg_we       (cfg_we),
    .cfg_port     (cfg_port),
    .cfg_dest     (cfg_dest),
    .credit_ret   (credit_ret),
    .credit_port  (credit_port),
    .credit_amt   (credit_amt),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_cred [N];
  int         m_seq  [N];
  bit         m_en   [N];
  logic [8:0] m_tbl  [N];
  int         m_last;
  bit         m_ov;
  bit         m_err;
  int         cnt    [N];
  logic [48:0] sb_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_cred[k] = MAXC;
      m_seq[k]  = 0;
      m_en[k]   = 0;
      m_tbl[k]  = '0;
    end
    m_last = N - 1;
    m_ov   = 0;
    m_err  = 0;
    sb_q.delete();
  endtask

  // One cycle of the reference model, evaluated after inputs settle.
  task automatic model();
    int g;
    int p;
    bit free;
    logic [N-1:0] exp_rdy;
    chk("pkt_valid", o_pkt_valid, m_ov);
    chk("credit_err", credit_err, m_err);
    if (reset) begin
      model_reset();
      return;
    end
    free = !m_ov || i_pkt_ready;
    g = -1;
    for (int i = 1; i <= N; i++) begin
      p = (m_last + i) % N;
      if (g < 0 && i_user_valid[p] && m_en[p] && m_cred[p] > 0) g = p;
    end
    exp_rdy = '0;
    if (free && g >= 0) exp_rdy[g] = 1'b1;
    chk("user_ready", o_user_ready, exp_rdy);
    for (int k = 0; k < N; k++) if (o_user_ready[k]) cnt[k]++;
    if (free && g >= 0) begin
      sb_q.push_back({1'b1, m_tbl[g], 7'(m_seq[g]), i_user_data[g*32 +: 32]});
      m_cred[g] = m_cred[g] - 1;
      m_seq[g]  = (m_seq[g] + 1) % 128;
      m_last    = g;
      m_ov      = 1;
    end else if (i_pkt_ready) begin
      m_ov = 0;
    end
    if (credit_ret) begin
      if (int'(credit_port) >= N) m_err = 1;
      else begin
        m_cred[credit_port] = m_cred[credit_port] + int'(credit_amt);
        if (m_cred[credit_port] > MAXC) begin
          m_cred[credit_port] = MAXC;
          m_err = 1;
        end
      end
    end
    if (cfg_we) begin
      if (int'(cfg_port) >= N) m_err = 1;
      else begin
        m_tbl[cfg_port] = cfg_dest;
        m_en[cfg_port]  = 1;
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    model();
    @(negedge clk);
  endtask

  task automatic clear_cnt();
    for (int k = 0; k < N; k++) cnt[k] = 0;
  endtask

  task automatic do_reset();
    i_user_valid = '0; cfg_we = 0; credit_ret = 0;
    reset = 1; step();
    reset = 0;
  endtask

  task automatic cfg_all();
    for (int p = 0; p < N; p++) begin
      cfg_we = 1; cfg_port = 3'(p); cfg_dest = {5'(p + 4), 4'(p + 8)};
      step();
    end
    cfg_we = 0;
  endtask

  // Monitor: compare each outbound packet on handshake; check hold under stall.
  logic [48:0] held;
  bit          hold_v = 0;
  always @(negedge clk) begin
    #2;
    if (reset) begin
      hold_v = 0;
    end else if (o_pkt_valid) begin
      if (hold_v) chk("pkt_hold", o_pkt, held);
      if (i_pkt_ready) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow actual=%0h required=none", o_pkt);
        end else begin
          chk("pkt", o_pkt, sb_q.pop_front());
        end
        hold_v = 0;
      end else begin
        hold_v = 1;
        held   = o_pkt;
      end
    end else begin
      hold_v = 0;
    end
  end

  initial begin
    reset = 1; i_user_data = '0; i_user_valid = '0; i_pkt_ready = 0;
    cfg_we = 0; cfg_port = 0; cfg_dest = 0;
    credit_ret = 0; credit_port = 0; credit_amt = 0;
    model_reset();
    clear_cnt();
    @(negedge clk);
    step();
    reset = 0;
    chk("rst_pkt", o_pkt, 49'h0);
    chk("rst_ready", o_user_ready, 4'h0);

    // Single port with a configured destination
    cfg_we = 1; cfg_port = 0; cfg_dest = {5'd3, 4'd1}; step();
    cfg_we = 0;
    i_user_valid = 4'b0001; i_user_data[31:0] = 32'hDEADBEEF; i_pkt_ready = 1;
    step();
    i_user_valid = '0;
    chk("single_pkt", o_pkt, 49'h1_1880_DEAD_BEEF);
    step();

    // Fairness with matched credit returns
    for (int p = 1; p < N; p++) begin
      cfg_we = 1; cfg_port = 3'(p); cfg_dest = {5'(p + 4), 4'(p)}; step();
    end
    cfg_we = 0;
    clear_cnt();
    i_user_valid = '1;
    for (int i = 0; i < 400; i++) begin
      i_user_data = {$urandom, $urandom, $urandom, $urandom};
      credit_ret = 1; credit_port = 3'(i % N); credit_amt = 7'd1;
      step();
    end
    credit_ret = 0; i_user_valid = '0;
    for (int k = 0; k < N; k++) chk("fair_count", cnt[k], 100);
    step();

    // Credit exhaustion on port 2, then a return of 5
    do_reset();
    cfg_we = 1; cfg_port = 2; cfg_dest = {5'd7, 4'd2}; step();
    cfg_we = 0;
    clear_cnt();
    i_user_valid = 4'b0100;
    for (int i = 0; i < 80; i++) begin
      i_user_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    chk("exhaust_count", cnt[2], 64);
    credit_ret = 1; credit_port = 2; credit_amt = 7'd5; step();
    credit_ret = 0;
    for (int i = 0; i < 10; i++) step();
    chk("return5_count", cnt[2], 69);

    // Backpressure with a pending packet
    credit_ret = 1; credit_port = 2; credit_amt = 7'd10; step();
    credit_ret = 0;
    i_user_data[95:64] = 32'hA5A5_0001; step();
    i_pkt_ready = 0;
    for (int i = 0; i < 10; i++) begin
      i_user_data[95:64] = $urandom;
      step();
    end
    chk("bp_count", cnt[2], 70);
    i_pkt_ready = 1;
    for (int i = 0; i < 3; i++) step();
    chk("bp_release_count", cnt[2], 73);
    i_user_valid = '0; step(); step();

    // Net decrement/return at full credit, then overflow
    do_reset();
    cfg_we = 1; cfg_port = 0; cfg_dest = {5'd1, 4'd1}; step();
    cfg_we = 0;
    i_user_valid = 4'b0001; credit_ret = 1; credit_port = 0; credit_amt = 7'd1;
    step();
    i_user_valid = '0; credit_ret = 0;
    chk("net_no_err", credit_err, 1'b0);
    credit_ret = 1; credit_amt = 7'd2; step();
    credit_ret = 0; step();
    chk("sat_err", credit_err, 1'b1);

    // Sequence address wrap on one port
    do_reset();
    cfg_we = 1; cfg_port = 3; cfg_dest = {5'd9, 4'd3}; step();
    cfg_we = 0;
    clear_cnt();
    i_user_valid = 4'b1000;
    for (int i = 0; i < 140; i++) begin
      i_user_data = {$urandom, $urandom, $urandom, $urandom};
      credit_ret = 1; credit_port = 3; credit_amt = 7'd1;
      step();
    end
    credit_ret = 0; i_user_valid = '0;
    chk("wrap_count", cnt[3], 140);
    step(); step();

    // Out-of-range configuration index
    do_reset();
    cfg_we = 1; cfg_port = 3'd6; cfg_dest = 9'h1FF; step();
    cfg_we = 0; step();
    chk("cfg_range_err", credit_err, 1'b1);

    // Reset with a packet pending; unconfigured ports stay quiet
    do_reset();
    cfg_all();
    i_user_valid = '1; i_pkt_ready = 1; step();
    i_pkt_ready = 0; step();
    reset = 1; step();
    reset = 0;
    chk("rst_mid_valid", o_pkt_valid, 1'b0);
    clear_cnt();
    i_pkt_ready = 1;
    for (int i = 0; i < 20; i++) step();
    chk("unconf_count", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
    cfg_we = 1; cfg_port = 1; cfg_dest = {5'd2, 4'd5}; step();
    cfg_we = 0;
    clear_cnt();
    for (int i = 0; i < 10; i++) step();
    chk("reconf_count", cnt[1], 10);
    chk("reconf_others", cnt[0] + cnt[2] + cnt[3], 0);

    // Randomized traffic
    i_user_valid = '0;
    do_reset();
    cfg_all();
    for (int i = 0; i < 1500; i++) begin
      reset        = (i == 750);
      i_user_data  = {$urandom, $urandom, $urandom, $urandom};
      i_user_valid = 4'($urandom);
      i_pkt_ready  = ($urandom % 10) < 7;
      credit_ret   = ($urandom % 4) == 0;
      credit_port  = 3'($urandom % 5);
      credit_amt   = 7'(1 + $urandom % 6);
      cfg_we       = ($urandom % 50) == 0 || i == 751 || i == 752;
      cfg_port     = (i == 751) ? 3'd0 : (i == 752) ? 3'd2 : 3'($urandom % 5);
      cfg_dest     = 9'($urandom);
      step();
    end
    reset = 0; cfg_we = 0; credit_ret = 0; i_user_valid = '0; i_pkt_ready = 1;
    for (int i = 0; i < 3; i++) step();
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Shares the single outbound BFT packet channel of a page between up to NUM_OUT_PORTS user output streams. It arbitrates round-robin and gates each stream on per-port credits returned by the destination leaf. It also stamps each payload beat with a configured destination leaf/port and a per-port sequence address. It sits between the user kernel output streams and the leaf interface's outbound packet side.

## Interface
Parameters:
- PACKET_BITS, 49: packet width; fixed layout [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload
- PAYLOAD_BITS, 32: user data width
- NUM_LEAF_BITS, 5: destination leaf field width
- NUM_PORT_BITS, 4: destination port field width
- NUM_ADDR_BITS, 7: sequence address width
- NUM_OUT_PORTS, 4: number of requesters, 1..8
- MAX_CREDITS, 64: credit count per port after reset; saturation limit

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_user_data  in  NUM_OUT_PORTS*PAYLOAD_BITS  per-port payload, port k at [k*32 +: 32]
- i_user_valid  in  NUM_OUT_PORTS  per-port valid
- o_user_ready  out  NUM_OUT_PORTS  per-port ready; one-hot or zero
- o_pkt  out  PACKET_BITS  outbound packet
- o_pkt_valid  out  1  outbound packet valid
- i_pkt_ready  in  1  downstream accepts o_pkt
- cfg_we  in  1  destination table write strobe
- cfg_port  in  3  table index
- cfg_dest  in  NUM_LEAF_BITS+NUM_PORT_BITS  {leaf, port}; writing also sets the entry's enable bit
- credit_ret  in  1  credit return strobe
- credit_port  in  3  port receiving credits
- credit_amt  in  7  credits returned, 1..64
- credit_err  out  1  sticky flag: return overflowed MAX_CREDITS, or port index out of range

## Operation
- Eligibility: port k is eligible when i_user_valid[k], enable[k], and credits[k] > 0 all hold.
- Arbitration:
  - Round-robin over eligible ports, starting at the port after last_grant.
  - last_grant resets to NUM_OUT_PORTS-1, so port 0 has first priority.
  - last_grant updates only on an actual transfer.
- Transfer condition: the output register is free (!o_pkt_valid || i_pkt_ready) and a grant exists. On transfer:
  - o_user_ready[g]=1 combinationally in the same cycle.
  - The packet is loaded with valid bit 1, dest table[g], addr seq[g], payload.
  - credits[g] is decremented.
  - seq[g] increments, wrapping 127 → 0.
- Credits:
  - A same-cycle decrement and return on one port apply net: new = old - 1 + amt.
  - If the result exceeds MAX_CREDITS, the count saturates at MAX_CREDITS and credit_err is set.
- Configuration:
  - A cfg_we write takes effect the next cycle and does not affect a packet already in the output register.
  - cfg_port or credit_port >= NUM_OUT_PORTS: the write is ignored and credit_err is set.
- FSM per port, 2 states:
  - ACTIVE: credits > 0.
  - STALLED: credits == 0. The port is never granted while STALLED.
  - STALLED → ACTIVE when a return is applied.

## Timing
- Reset values:
  - o_pkt=0, o_pkt_valid=0, o_user_ready=0, credit_err=0.
  - credits[k]=MAX_CREDITS, seq[k]=0, enable[k]=0, table=0.
- Latency: user beat accepted in cycle N → o_pkt_valid=1 in cycle N+1.
- Throughput: one packet per cycle while i_pkt_ready=1.
- o_pkt and o_pkt_valid hold stable while o_pkt_valid && !i_pkt_ready.
- o_user_ready depends combinationally on i_user_valid, credits, and i_pkt_ready. There is no combinational path from i_pkt_ready to o_pkt.
- Reset mid-operation: a pending o_pkt is dropped, all credits and sequence numbers reinitialise, and table enables clear.

## Structure
- Package leaf_pkt_pkg holds:
  - field offsets and widths (VALID_BIT=48, LEAF_LSB=43, PORT_LSB=39, ADDR_LSB=32)
  - a pack function {1, leaf, port, addr, payload}
  - the CREDIT_BITS constant = $clog2(MAX_CREDITS+1)
- Sub-module rr_arbiter: parameterised NUM_REQ. Inputs are req vector and advance strobe; output is a one-hot grant; it holds its own last_grant register.
- Top level holds the credit counters, sequence counters, config table, and output register.

## Test plan
- Single port: configure port 0 → {leaf 3, port 1}, send payload 0xDEADBEEF with ready high → next cycle o_pkt = {1, 5'd3, 4'd1, 7'd0, 32'hDEADBEEF}, and credits[0] becomes 63.
- Fairness: all 4 ports enabled and continuously valid → grants cycle 0,1,2,3,0; over 400 cycles each port gets exactly 100 packets.
- Credit exhaustion: port 2 sends 64 beats with no returns → the 65th beat stalls with o_user_ready[2]=0. Return credit_amt=5 → exactly 5 more packets pass, with addr continuing 64..68.
- Backpressure: i_pkt_ready low for 10 cycles with a packet pending → o_pkt stable, all o_user_ready=0, no credit change. Release → the held packet is sent first.
- Boundary: a same-cycle transfer and return of 1 on a port holding 64 credits → stays 64 with no error. A return of 2 at 64 credits → saturates at 64 and sets credit_err. After 128 packets on one port, addr wraps to 0.
- Reset mid-stream: assert reset with o_pkt_valid=1 → next cycle o_pkt_valid=0 and credits=64. Unconfigured ports are never granted until rewritten.
